// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver driven by an 8x-baud sample enable; each bit is decided by a
// 3-sample majority vote around mid-bit, with a one-deep output holding register.
module uart_rx_oversample #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_en,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [2:0]             tc;
    logic [2:0]             bi;
    logic [7:0]             shift_q;
    logic                   smp2;
    logic                   smp3;
    logic                   vote;
    logic                   decide;
    logic                   byte_done;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Line synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign vote      = maj3(smp2, smp3, rxs);
    assign decide    = rx_en && (tc == 3'd4);
    assign byte_done = decide && (state == S_STOP) && vote;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tc        <= 3'd0;
            bi        <= 3'd0;
            shift_q   <= 8'h00;
            smp2      <= 1'b1;
            smp3      <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_en) begin
                if (state == S_START || state == S_DATA || state == S_STOP) begin
                    tc <= tc + 3'd1;
                    if (tc == 3'd2) smp2 <= rxs;
                    if (tc == 3'd3) smp3 <= rxs;
                end
                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            state <= S_START;
                            tc    <= 3'd0;
                        end
                    end
                    S_START: begin
                        if (decide && vote) begin
                            state <= S_IDLE;
                        end else if (tc == 3'd7) begin
                            state <= S_DATA;
                            bi    <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (decide) shift_q <= {vote, shift_q[7:1]};
                        if (tc == 3'd7) begin
                            if (bi == 3'd7) state <= S_STOP;
                            else            bi    <= bi + 3'd1;
                        end
                    end
                    S_STOP: begin
                        // Leave mid-stop-bit so the next start edge is caught promptly
                        if (decide) begin
                            if (vote) begin
                                state <= S_IDLE;
                            end else begin
                                state     <= S_BRK;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    S_BRK: begin
                        if (rxs) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Holding register: an ack in the completing cycle frees the slot for the new byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (byte_done && (!rx_valid || rx_ack)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
            if (byte_done && rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frames driven bit by bit against an
// 8x sample enable, outputs observed on the falling clock edge.
module tb_uart_rx_oversample;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx_en   = 1'b0;
    logic       rxd     = 1'b1;
    logic       rx_ack  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         rx_cnt  = 0;
    int         fe_cnt  = 0;
    int         fe_wide = 0;
    int         v_hi    = 0;
    logic [7:0] last_byte = 8'h00;
    logic       prev_v  = 1'b0;
    logic       prev_fe = 1'b0;
    int         base_rx;
    int         base_fe;
    int         base_vhi;

    uart_rx_oversample #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_en     (rx_en),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One-clk rx_en pulse every 24 clocks
    initial begin
        forever begin
            repeat (23) @(negedge clk);
            rx_en = 1'b1;
            @(negedge clk);
            rx_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid && !prev_v) begin
            rx_cnt++;
            last_byte = rx_data;
        end
        if (rx_valid) v_hi++;
        if (frame_err) begin
            fe_cnt++;
            if (prev_fe) fe_wide++;
        end
        prev_v  = rx_valid;
        prev_fe = frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk iff rx_en);
        #1;
    endtask

    // Line is left at the stop-bit level on return
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_ticks(8);
        end
        rxd = stop_bit;
        wait_ticks(8);
    endtask

    // Single-clk low glitch arranged so it is seen at tc=3 of data bit gbit
    task automatic send_frame_glitch(input logic [7:0] b, input int gbit);
        rxd = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == gbit) begin
                wait_ticks(4);
                repeat (21) @(posedge clk);
                #1 rxd = 1'b0;
                @(posedge clk);
                #1 rxd = b[i];
                wait_ticks(4);
            end else begin
                wait_ticks(8);
            end
        end
        rxd = 1'b1;
        wait_ticks(8);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_valid", 32'(rx_valid), 32'h0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        wait_ticks(2);

        // Back-to-back bytes with ack held high
        rx_ack   = 1'b1;
        base_rx  = rx_cnt;
        base_vhi = v_hi;
        send_frame(8'h55, 1'b1);
        chk("b55_count", 32'(rx_cnt - base_rx), 32'd1);
        chk("b55_data", 32'(last_byte), 32'h55);
        wait_ticks(2);
        send_frame(8'hA3, 1'b1);
        chk("bA3_count", 32'(rx_cnt - base_rx), 32'd2);
        chk("bA3_data", 32'(last_byte), 32'hA3);
        chk("ack_valid_width", 32'(v_hi - base_vhi), 32'd2);
        chk("clean_frame_err", 32'(fe_cnt), 32'd0);
        chk("clean_overrun", 32'(overrun), 32'h0);
        wait_ticks(2);

        // False start: low for two ticks only
        base_rx = rx_cnt;
        rxd = 1'b0;
        wait_ticks(2);
        rxd = 1'b1;
        wait_ticks(2);
        chk("false_start_busy", 32'(busy), 32'h1);
        wait_ticks(3);
        chk("false_start_idle", 32'(busy), 32'h0);
        chk("false_start_no_byte", 32'(rx_cnt - base_rx), 32'd0);
        chk("false_start_no_fe", 32'(fe_cnt), 32'd0);
        wait_ticks(2);

        // Framing error followed by a long break
        base_rx = rx_cnt;
        base_fe = fe_cnt;
        send_frame(8'h3C, 1'b0);
        wait_ticks(152);
        chk("break_fe_count", 32'(fe_cnt - base_fe), 32'd1);
        chk("break_fe_width", 32'(fe_wide), 32'd0);
        chk("break_no_byte", 32'(rx_cnt - base_rx), 32'd0);
        chk("break_busy", 32'(busy), 32'h1);
        rxd = 1'b1;
        wait_ticks(2);
        chk("break_end_idle", 32'(busy), 32'h0);
        send_frame(8'h81, 1'b1);
        chk("after_break_count", 32'(rx_cnt - base_rx), 32'd1);
        chk("after_break_data", 32'(last_byte), 32'h81);
        wait_ticks(2);

        // Glitch on a data bit of 0xFF must be voted out
        send_frame_glitch(8'hFF, 2);
        chk("glitch_data", 32'(last_byte), 32'hFF);
        chk("glitch_count", 32'(rx_cnt - base_rx), 32'd2);
        wait_ticks(2);

        // Overrun with no acknowledge
        rx_ack  = 1'b0;
        base_rx = rx_cnt;
        send_frame(8'h11, 1'b1);
        chk("ovr_first_valid", 32'(rx_valid), 32'h1);
        chk("ovr_first_data", 32'(rx_data), 32'h11);
        chk("ovr_first_flag", 32'(overrun), 32'h0);
        wait_ticks(2);
        send_frame(8'h22, 1'b1);
        chk("ovr_data_kept", 32'(rx_data), 32'h11);
        chk("ovr_flag_set", 32'(overrun), 32'h1);
        chk("ovr_valid_held", 32'(rx_valid), 32'h1);
        chk("ovr_one_delivery", 32'(rx_cnt - base_rx), 32'd1);
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        chk("ack_clears_valid", 32'(rx_valid), 32'h0);
        chk("ack_clears_overrun", 32'(overrun), 32'h0);
        chk("ack_data_kept", 32'(rx_data), 32'h11);
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        chk("idle_ack_no_effect", 32'(rx_valid), 32'h0);
        chk("idle_ack_data_kept", 32'(rx_data), 32'h11);
        wait_ticks(2);

        // Reset mid-frame during bit 4 of 0xF0
        rx_ack  = 1'b1;
        base_rx = rx_cnt;
        rxd = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b0;
            wait_ticks(8);
        end
        rxd = 1'b1;
        wait_ticks(4);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_data", 32'(rx_data), 32'h00);
        chk("async_reset_busy", 32'(busy), 32'h0);
        chk("async_reset_valid", 32'(rx_valid), 32'h0);
        chk("async_reset_overrun", 32'(overrun), 32'h0);
        chk("async_reset_fe", 32'(frame_err), 32'h0);
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
        wait_ticks(4);
        wait_ticks(32);
        chk("abandoned_no_byte", 32'(rx_cnt - base_rx), 32'd0);
        chk("abandoned_idle", 32'(busy), 32'h0);
        send_frame(8'h0F, 1'b1);
        chk("post_reset_count", 32'(rx_cnt - base_rx), 32'd1);
        chk("post_reset_data", 32'(last_byte), 32'h0F);
        wait_ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
